// File: rtl/regfile_pkg.sv
// regfile_pkg: shared constants and types for the regfile_clr register bank.
// Build option REGFILE_BYPASS_EN enables write-through read forwarding.
package regfile_pkg;

  localparam int RF_WIDTH = 32;
  localparam int RF_DEPTH = 16;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } clr_state_e;

  // A single-entry file still needs a one-bit address.
  function automatic int addr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/regfile_rd_port.sv
// regfile_rd_port: registered read mux with valid strobe and range check.
// Build option REGFILE_BYPASS_EN forwards a same-cycle write to the read.
module regfile_rd_port
  import regfile_pkg::*;
#(
  parameter int WIDTH  = RF_WIDTH,
  parameter int DEPTH  = RF_DEPTH,
  parameter int ADDR_W = addr_w(RF_DEPTH)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              i_en,
  input  logic              i_busy,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [WIDTH-1:0]  i_mem [DEPTH],
  input  logic              i_wr_fire,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [WIDTH-1:0]  i_wr_data,
  output logic [WIDTH-1:0]  o_data,
  output logic              o_valid
);

  logic             w_accept;
  logic             w_in_range;
  logic [WIDTH-1:0] w_next;
  logic [WIDTH-1:0] r_data;
  logic             r_valid;

  assign w_accept   = i_en & ~i_busy;
  assign w_in_range = ({1'b0, i_addr} < (ADDR_W+1)'(DEPTH));

`ifdef REGFILE_BYPASS_EN
  always_comb begin
    w_next = '0;
    if (w_in_range) begin
      if (i_wr_fire && (i_wr_addr == i_addr))
        w_next = i_wr_data;
      else
        w_next = i_mem[i_addr];
    end
  end
`else
  logic w_unused_byp;
  assign w_unused_byp = ^{i_wr_fire, i_wr_addr, i_wr_data};

  always_comb begin
    w_next = '0;
    if (w_in_range)
      w_next = i_mem[i_addr];
  end
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_data  <= '0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= w_accept;
      if (w_accept)
        r_data <= w_next;
    end
  end

  assign o_data  = r_data;
  assign o_valid = r_valid;

endmodule

// File: rtl/regfile_clr.sv
// regfile_clr: 1W2R register file with valid bitmap and sequenced clear.
// Build option REGFILE_BYPASS_EN enables write-through read forwarding.
module regfile_clr
  import regfile_pkg::*;
#(
  parameter int  WIDTH  = RF_WIDTH,
  parameter int  DEPTH  = RF_DEPTH,
  localparam int ADDR_W = addr_w(DEPTH)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic              rd0_en,
  input  logic [ADDR_W-1:0] rd0_addr,
  output logic [WIDTH-1:0]  rd0_data,
  output logic              rd0_valid,
  input  logic              rd1_en,
  input  logic [ADDR_W-1:0] rd1_addr,
  output logic [WIDTH-1:0]  rd1_data,
  output logic              rd1_valid,
  input  logic              clr_req,
  output logic              busy,
  output logic [DEPTH-1:0]  valid_map
);

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  logic [WIDTH-1:0]  r_mem [DEPTH];
  logic [DEPTH-1:0]  r_valid_map;
  clr_state_e        r_state;
  logic [ADDR_W-1:0] r_cnt;
  logic              r_busy;
  logic              w_wr_in_range;
  logic              w_wr_fire;

  assign w_wr_in_range = ({1'b0, wr_addr} < (ADDR_W+1)'(DEPTH));
  assign w_wr_fire     = wr_en & ~r_busy & w_wr_in_range;

  // Writes are blocked while clearing, so the two never collide.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++)
        r_mem[i] <= '0;
      r_valid_map <= '0;
    end else if (r_state == CLEAR) begin
      r_mem[r_cnt]       <= '0;
      r_valid_map[r_cnt] <= 1'b0;
    end else if (w_wr_fire) begin
      r_mem[wr_addr]       <= wr_data;
      r_valid_map[wr_addr] <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (clr_req) begin
            r_state <= CLEAR;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
          end
        end
        CLEAR: begin
          if (r_cnt == LAST) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
      endcase
    end
  end

  regfile_rd_port #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .ADDR_W(ADDR_W)
  ) u_rd0 (
    .clk      (clk),
    .reset_n  (reset_n),
    .i_en     (rd0_en),
    .i_busy   (r_busy),
    .i_addr   (rd0_addr),
    .i_mem    (r_mem),
    .i_wr_fire(w_wr_fire),
    .i_wr_addr(wr_addr),
    .i_wr_data(wr_data),
    .o_data   (rd0_data),
    .o_valid  (rd0_valid)
  );

  regfile_rd_port #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .ADDR_W(ADDR_W)
  ) u_rd1 (
    .clk      (clk),
    .reset_n  (reset_n),
    .i_en     (rd1_en),
    .i_busy   (r_busy),
    .i_addr   (rd1_addr),
    .i_mem    (r_mem),
    .i_wr_fire(w_wr_fire),
    .i_wr_addr(wr_addr),
    .i_wr_data(wr_data),
    .o_data   (rd1_data),
    .o_valid  (rd1_valid)
  );

  assign busy      = r_busy;
  assign valid_map = r_valid_map;

endmodule

// File: tb/tb_regfile_clr.sv
// tb_regfile_clr: directed scoreboard bench for regfile_clr.
// Runs a DEPTH=16 and a DEPTH=12 instance side by side.
module tb_regfile_clr;
  import regfile_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;

  logic        wr_en = 1'b0;
  logic [3:0]  wr_addr = '0;
  logic [31:0] wr_data = '0;
  logic        rd0_en = 1'b0;
  logic [3:0]  rd0_addr = '0;
  logic [31:0] rd0_data;
  logic        rd0_valid;
  logic        rd1_en = 1'b0;
  logic [3:0]  rd1_addr = '0;
  logic [31:0] rd1_data;
  logic        rd1_valid;
  logic        clr_req = 1'b0;
  logic        busy;
  logic [15:0] valid_map;

  logic        b_wr_en = 1'b0;
  logic [3:0]  b_wr_addr = '0;
  logic [31:0] b_wr_data = '0;
  logic        b_rd0_en = 1'b0;
  logic [3:0]  b_rd0_addr = '0;
  logic [31:0] b_rd0_data;
  logic        b_rd0_valid;
  logic        b_rd1_en = 1'b0;
  logic [3:0]  b_rd1_addr = '0;
  logic [31:0] b_rd1_data;
  logic        b_rd1_valid;
  logic        b_clr_req = 1'b0;
  logic        b_busy;
  logic [11:0] b_valid_map;

  int checks = 0;
  int failures = 0;

  logic [31:0] q0[$];
  logic [31:0] q1[$];
  logic [31:0] qb[$];
  bit          p0, p1, pb;
  logic [31:0] last0, last1, lastb;
  logic [31:0] m [16];
  logic [31:0] e;

  regfile_clr u_dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .rd0_en   (rd0_en),
    .rd0_addr (rd0_addr),
    .rd0_data (rd0_data),
    .rd0_valid(rd0_valid),
    .rd1_en   (rd1_en),
    .rd1_addr (rd1_addr),
    .rd1_data (rd1_data),
    .rd1_valid(rd1_valid),
    .clr_req  (clr_req),
    .busy     (busy),
    .valid_map(valid_map)
  );

  regfile_clr #(.WIDTH(32), .DEPTH(12)) u_dut12 (
    .clk      (clk),
    .reset_n  (reset_n),
    .wr_en    (b_wr_en),
    .wr_addr  (b_wr_addr),
    .wr_data  (b_wr_data),
    .rd0_en   (b_rd0_en),
    .rd0_addr (b_rd0_addr),
    .rd0_data (b_rd0_data),
    .rd0_valid(b_rd0_valid),
    .rd1_en   (b_rd1_en),
    .rd1_addr (b_rd1_addr),
    .rd1_data (b_rd1_data),
    .rd1_valid(b_rd1_valid),
    .clr_req  (b_clr_req),
    .busy     (b_busy),
    .valid_map(b_valid_map)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic rd0(input int a, input logic [31:0] x);
    rd0_en = 1'b1; rd0_addr = 4'(a); q0.push_back(x); p0 = 1'b1;
  endtask

  task automatic rd1(input int a, input logic [31:0] x);
    rd1_en = 1'b1; rd1_addr = 4'(a); q1.push_back(x); p1 = 1'b1;
  endtask

  task automatic brd(input int a, input logic [31:0] x);
    b_rd0_en = 1'b1; b_rd0_addr = 4'(a); qb.push_back(x); pb = 1'b1;
  endtask

  task automatic wr(input int a, input logic [31:0] d, input bit acc);
    wr_en = 1'b1; wr_addr = 4'(a); wr_data = d;
    if (acc) m[a] = d;
  endtask

  task automatic bwr(input int a, input logic [31:0] d);
    b_wr_en = 1'b1; b_wr_addr = 4'(a); b_wr_data = d;
  endtask

  // One clock: pop expected reads, otherwise require idle strobe + held data.
  task automatic tick();
    logic [31:0] x;
    @(posedge clk); #1;
    if (p0) begin
      x = q0.pop_front();
      chk("rd0_valid", 32'(rd0_valid), 32'd1);
      chk("rd0_data", rd0_data, x);
      last0 = x;
    end else begin
      chk("rd0_idle", 32'(rd0_valid), 32'd0);
      chk("rd0_hold", rd0_data, last0);
    end
    if (p1) begin
      x = q1.pop_front();
      chk("rd1_valid", 32'(rd1_valid), 32'd1);
      chk("rd1_data", rd1_data, x);
      last1 = x;
    end else begin
      chk("rd1_idle", 32'(rd1_valid), 32'd0);
      chk("rd1_hold", rd1_data, last1);
    end
    if (pb) begin
      x = qb.pop_front();
      chk("b_rd0_valid", 32'(b_rd0_valid), 32'd1);
      chk("b_rd0_data", b_rd0_data, x);
      lastb = x;
    end else begin
      chk("b_rd0_idle", 32'(b_rd0_valid), 32'd0);
      chk("b_rd0_hold", b_rd0_data, lastb);
    end
    p0 = 1'b0; p1 = 1'b0; pb = 1'b0;
    wr_en = 1'b0; rd0_en = 1'b0; rd1_en = 1'b0; clr_req = 1'b0;
    b_wr_en = 1'b0; b_rd0_en = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) m[i] = '0;
    last0 = '0; last1 = '0; lastb = '0;
    p0 = 1'b0; p1 = 1'b0; pb = 1'b0;

    #12;
    chk("rst_rd0_data", rd0_data, 32'd0);
    chk("rst_rd0_valid", 32'(rd0_valid), 32'd0);
    chk("rst_rd1_data", rd1_data, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_vmap", 32'(valid_map), 32'd0);
    @(negedge clk) reset_n = 1'b1;
    tick();

    for (int a = 0; a < 16; a++) begin
      rd0(a, 32'd0); rd1(15 - a, 32'd0); tick();
    end
    chk("vmap_after_rst", 32'(valid_map), 32'h0000);

    wr(5, 32'hDEADBEEF, 1'b1); tick();
    rd0(5, 32'hDEADBEEF); rd1(4, 32'd0); tick();
    chk("vmap_addr5", 32'(valid_map), 32'h0020);

    wr(3, 32'hAAAA, 1'b1); tick();
`ifdef REGFILE_BYPASS_EN
    e = 32'h1234;
`else
    e = 32'hAAAA;
`endif
    rd0(3, e); rd1(3, e); wr(3, 32'h1234, 1'b1); tick();
    rd0(3, 32'h1234); tick();
    chk("vmap_addr3_5", 32'(valid_map), 32'h0028);

    for (int i = 0; i < 16; i++) begin
      wr(i, 32'h1000_0000 + 32'(i) * 32'h0101, 1'b1); tick();
    end
    chk("vmap_full", 32'(valid_map), 32'hFFFF);

    clr_req = 1'b1;
    rd0(2, m[2]); rd1(15, m[15]);
    wr(0, 32'hCAFE0000, 1'b1);
    tick();
    for (int i = 0; i < 16; i++) begin
      chk("busy_during_clr", 32'(busy), 32'd1);
      wr(i, 32'h5A5A0000 + 32'(i), 1'b0);
      rd0_en = 1'b1; rd0_addr = 4'(i);
      if (i == 5) clr_req = 1'b1;
      tick();
    end
    chk("busy_after_clr", 32'(busy), 32'd0);
    chk("vmap_after_clr", 32'(valid_map), 32'h0000);
    for (int i = 0; i < 16; i++) m[i] = '0;
    for (int a = 0; a < 16; a++) begin
      rd0(a, m[a]); rd1(15 - a, m[15 - a]); tick();
    end

    wr(10, 32'h0000_00AB, 1'b1); tick();
    wr(12, 32'h0000_00CD, 1'b1); tick();
    clr_req = 1'b1; tick();
    repeat (6) tick();
    chk("busy_mid_clr", 32'(busy), 32'd1);
    chk("cnt_mid_clr", 32'(u_dut.r_cnt), 32'd6);
    #2 reset_n = 1'b0;
    #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_state", 32'(u_dut.r_state), 32'(IDLE));
    chk("abort_cnt", 32'(u_dut.r_cnt), 32'd0);
    chk("abort_vmap", 32'(valid_map), 32'd0);
    chk("abort_rd0_valid", 32'(rd0_valid), 32'd0);
    chk("abort_rd0_data", rd0_data, 32'd0);
    for (int i = 0; i < 16; i++) m[i] = '0;
    last0 = '0; last1 = '0; lastb = '0;
    @(negedge clk) reset_n = 1'b1;
    rd0(10, 32'd0); rd1(12, 32'd0); tick();
    clr_req = 1'b1; tick();
    for (int i = 0; i < 16; i++) begin
      chk("busy_reclr", 32'(busy), 32'd1);
      tick();
    end
    chk("busy_after_reclr", 32'(busy), 32'd0);

    bwr(13, 32'hBAD0BAD0); brd(13, 32'd0); tick();
    chk("b_vmap_oor", 32'(b_valid_map), 32'h000);
    brd(13, 32'd0); tick();
    for (int a = 0; a < 12; a++) begin
      brd(a, 32'd0); tick();
    end
    bwr(11, 32'd77); tick();
    brd(11, 32'd77); tick();
    chk("b_vmap_11", 32'(b_valid_map), 32'h800);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/regfile_clr.md
Name: regfile_clr

Overview:
- Parametrised successor to the fixed 16x32 load-register bank.
- One write port with address decode; two independent read ports, each with a registered output and a valid strobe.
- A per-entry valid bitmap tracks which entries have been written since reset or the last clear.
- A sequenced clear engine zeroes the file one entry per cycle. The block is the general-purpose register storage for datapath blocks in the design.

Parameters:
- WIDTH, 32, data width of each entry in bits.
- DEPTH, 16, number of entries; need not be a power of two.
- ADDR_W, $clog2(DEPTH), address width; derived localparam, not overridable.

Ports:
- clk  input  1  rising-edge clock.
- reset_n  input  1  asynchronous active-low reset.
- wr_en  input  1  write request.
- wr_addr  input  ADDR_W  write address.
- wr_data  input  WIDTH  write data.
- rd0_en  input  1  read request, port 0.
- rd0_addr  input  ADDR_W  read address, port 0.
- rd0_data  output  WIDTH  registered read data, port 0.
- rd0_valid  output  1  one-cycle strobe; rd0_data is valid.
- rd1_en, rd1_addr, rd1_data, rd1_valid: same as port 0, for port 1.
- clr_req  input  1  single-cycle pulse; starts a clear sequence.
- busy  output  1  high while the clear sequence runs.
- valid_map  output  DEPTH  bit i set means entry i has been written since reset or the last clear.

Behaviour:
- Reset (reset_n low, async):
  - all entries 0; rd0/rd1_data 0; rd0/rd1_valid 0; busy 0; valid_map 0; FSM in IDLE; clear counter 0.
  - Reset asserted mid-clear aborts the sequence immediately; all state returns to reset values.
- Write:
  - At posedge, if wr_en=1, busy=0 and wr_addr<DEPTH: mem[wr_addr]<=wr_data and valid_map[wr_addr]<=1.
  - wr_addr>=DEPTH: write silently dropped.
  - Writes while busy=1: dropped; no error flag.
- Read, each port independent, latency 1:
  - If rdN_en=1 and busy=0 at edge k, then at edge k+1 rdN_data=mem[rdN_addr] and rdN_valid=1.
  - rdN_addr>=DEPTH: rdN_data=0 and rdN_valid=1.
  - rdN_en=0 or busy=1: rdN_valid=0 and rdN_data holds its last value.
  - Both ports may read the same address in the same cycle.
- Read/write same address in the same cycle: read returns the old contents; see the optional feature for the alternative.
- Clear FSM, states IDLE and CLEAR:
  - IDLE, clr_req=1 -> CLEAR; busy=1 from the next cycle; counter=0.
  - CLEAR, each cycle: mem[counter]<=0, valid_map[counter]<=0, counter++.
  - When counter==DEPTH-1, that entry is cleared, then -> IDLE; busy drops the following cycle.
  - busy is high for exactly DEPTH cycles.
  - clr_req while in CLEAR is ignored; it does not restart the sequence.
  - clr_req and wr_en in the same IDLE cycle: the write commits that cycle, then the clear wipes it.
  - Read and clr_req in the same IDLE cycle: the read is accepted and returns pre-clear data.

Optional Feature:
- Macro REGFILE_BYPASS_EN.
- Defined: when wr_en is accepted and rdN_en=1 with rdN_addr==wr_addr in the same cycle, rdN_data on the next edge equals wr_data (write-through forwarding on each port independently).
- Undefined: that read returns the pre-write contents.
- No other behaviour differs.

Decomposition:
- Shared package regfile_pkg:
  - default WIDTH and DEPTH constants;
  - enum typedef for the FSM states (IDLE, CLEAR).
- One natural sub-module, regfile_rd_port, instantiated twice. It contains the registered read mux, the valid strobe, out-of-range handling and bypass compare.
- Storage, write decode, valid_map and the clear FSM remain in the top module.

Test Plan:
- Reset then read each address on both ports -> every rdN_data=0 with rdN_valid=1 one cycle later; valid_map=16'h0000.
- Write 32'hDEADBEEF to addr 5; next cycle read addr 5 on port 0 and addr 4 on port 1 -> rd0_data=32'hDEADBEEF, rd1_data=0; valid_map=16'h0020.
- Write 32'h1234 and read addr 3 in the same cycle, addr 3 previously holding 32'hAAAA -> rd0_data=32'hAAAA without REGFILE_BYPASS_EN, 32'h1234 with it.
- Fill all 16 entries, then pulse clr_req -> busy high for exactly 16 cycles; writes issued during busy are dropped; afterwards all reads return 0 and valid_map=0.
- Assert reset_n low at cycle 7 of a clear -> busy=0 immediately; FSM in IDLE; a subsequent clr_req runs the full 16 cycles again.
- DEPTH=12: write to addr 13 -> no entry changes; read addr 13 -> rd0_data=0 with rd0_valid=1.
